// File: rtl/id_branch_predictor.sv
// Dynamic branch predictor: 2-bit saturating counters plus a tagged target buffer, cleared by an init sweep.
// Optional gshare indexing of the counter table is enabled with the BPRED_GHR_EN macro.
module id_branch_predictor #(
   parameter int unsigned ENTRIES  = 64,
   parameter int unsigned TAG_W    = 8,
   parameter logic [1:0]  CTR_INIT = 2'b01,
   parameter int unsigned GHR_W    = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic        ready,
   input  logic [31:0] lookup_pc,
   output logic        pred_taken,
   output logic        pred_hit,
   output logic [31:0] pred_target,
   input  logic        update_valid,
   input  logic        update_is_branch,
   input  logic [31:0] update_pc,
   input  logic        update_taken,
   input  logic [31:0] update_target,
   input  logic        update_pred_taken,
   input  logic [31:0] update_pred_tgt,
   output logic        mispredict,
   output logic [31:0] redirect_pc,
   output logic [31:0] branch_count,
   output logic [31:0] miss_count
);
   // state  | meaning
   // S_INIT | sweeping one table entry per cycle; lookups and updates suppressed
   // S_RUN  | normal predict/update operation until the next reset
   localparam int unsigned IDX_W = $clog2(ENTRIES);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [IDX_W-1:0] ptr_q, ptr_d;
   logic             sweep_we;

   logic [ENTRIES-1:0] valid_q;
   logic [TAG_W-1:0]   tag_q [ENTRIES];
   logic [31:0]        tgt_q [ENTRIES];
   logic [1:0]         ctr_q [ENTRIES];

   logic [IDX_W-1:0] lk_idx, up_idx, lk_cidx, up_cidx, ghr_ext;
   logic [TAG_W-1:0] lk_tag, up_tag;
   logic             run, upd, br_upd, scrub, lk_hit, up_hit, mis_d;
   logic [1:0]       ctr_old, ctr_new;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_INIT;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      sweep_we = 1'b0;
      if (state_q == S_INIT) begin
         sweep_we = 1'b1;
         ptr_d    = ptr_q + 1'b1;
         if (ptr_q == IDX_W'(ENTRIES - 1)) state_d = S_RUN;
      end
   end

   assign run    = (state_q == S_RUN);
   assign ready  = run;
   assign upd    = run & update_valid;
   assign br_upd = upd & update_is_branch;

   assign lk_idx = lookup_pc[IDX_W+1:2];
   assign lk_tag = lookup_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign up_idx = update_pc[IDX_W+1:2];
   assign up_tag = update_pc[IDX_W+TAG_W+1:IDX_W+2];

`ifdef BPRED_GHR_EN
   logic [GHR_W-1:0] ghr_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 ghr_q <= '0;
      else if (state_q == S_INIT) ghr_q <= '0;
      else if (br_upd)            ghr_q <= GHR_W'({ghr_q, update_taken});
   end

   assign ghr_ext = IDX_W'(ghr_q);
`else
   assign ghr_ext = '0;
`endif

   // Only the direction counters are history-hashed; tag and target stay PC-indexed.
   assign lk_cidx = lk_idx ^ ghr_ext;
   assign up_cidx = up_idx ^ ghr_ext;

   assign lk_hit      = run & valid_q[lk_idx] & (tag_q[lk_idx] == lk_tag);
   assign pred_hit    = lk_hit;
   assign pred_taken  = lk_hit & ctr_q[lk_cidx][1];
   assign pred_target = lk_hit ? tgt_q[lk_idx] : '0;

   assign up_hit  = valid_q[up_idx] & (tag_q[up_idx] == up_tag);
   assign scrub   = upd & ~update_is_branch & up_hit;
   assign ctr_old = ctr_q[up_cidx];

   // A tag miss means the counter belongs to another branch: restart it weakly toward the outcome.
   always_comb begin
      ctr_new = ctr_old;
      if (!up_hit)                 ctr_new = update_taken ? 2'b10 : 2'b01;
      else if (update_taken) begin
         if (ctr_old != 2'b11)     ctr_new = ctr_old + 2'b01;
      end else if (ctr_old != 2'b00) ctr_new = ctr_old - 2'b01;
   end

   always_ff @(posedge clk) begin
      if (sweep_we) begin
         valid_q[ptr_q] <= 1'b0;
         ctr_q[ptr_q]   <= CTR_INIT;
      end else begin
         if (br_upd) begin
            ctr_q[up_cidx] <= ctr_new;
            if (update_taken) begin
               valid_q[up_idx] <= 1'b1;
               tag_q[up_idx]   <= up_tag;
               tgt_q[up_idx]   <= update_target;
            end
         end
         if (scrub) valid_q[up_idx] <= 1'b0;
      end
   end

   assign mis_d = upd & (update_is_branch
                  ? ((update_pred_taken != update_taken) |
                     (update_taken & (update_pred_tgt != update_target)))
                  : update_pred_taken);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mispredict   <= 1'b0;
         redirect_pc  <= '0;
         branch_count <= '0;
         miss_count   <= '0;
      end else begin
         mispredict <= mis_d;
         if (mis_d) begin
            redirect_pc <= (update_is_branch & update_taken) ? update_target : update_pc + 32'd4;
            if (miss_count != '1) miss_count <= miss_count + 32'd1;
         end
         if (br_upd && branch_count != '1) branch_count <= branch_count + 32'd1;
      end
   end
endmodule
